// File: rtl/window_gen_3x3_pkg.sv
// window_gen_3x3_pkg: shared window geometry (3x3, 9 taps), default pixel width and window slice macro
`ifndef WINDOW_GEN_3X3_PKG_SV
`define WINDOW_GEN_3X3_PKG_SV
`define WIN_SLICE(k, b) (b)*(9-(k))-1:(b)*(8-(k))
package window_gen_3x3_pkg;
  localparam int BIT_DEPTH = 16;
  localparam int WIN_K = 3;
  localparam int WIN_N = WIN_K * WIN_K;
endpackage
`endif

// File: rtl/window_gen_3x3_line_buf.sv
// window_gen_3x3_line_buf: one-row delay line (depth pixels), shifts only when en; ports clk, en, din, dout
module window_gen_3x3_line_buf #(
  parameter int W = 16,
  parameter int DEPTH = 28
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: row-major pixel stream to 3x3 sliding windows; ports clk, RESET, pix_valid/pix_sof/pix_in in, win_out/win_valid/win_row/win_col/frame_done out; WIN_STRIDE2_EN selects stride-2 window gating
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int bit_depth = BIT_DEPTH,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int COL_W = 5,
  parameter int ROW_W = 5
) (
  input  logic                       clk,
  input  logic                       RESET,
  input  logic                       pix_valid,
  input  logic                       pix_sof,
  input  logic [bit_depth-1:0]       pix_in,
  output logic [bit_depth*WIN_N-1:0] win_out,
  output logic                       win_valid,
  output logic [ROW_W-1:0]           win_row,
  output logic [COL_W-1:0]           win_col,
  output logic                       frame_done
);
  logic [COL_W-1:0] col, cur_c;
  logic [ROW_W-1:0] row, cur_r;
  logic [bit_depth-1:0] w [WIN_N];
  logic [bit_depth-1:0] lb1, lb2;
  logic last_c, last_r, win_ok;
  window_gen_3x3_line_buf #(.W(bit_depth), .DEPTH(IMG_W)) u_lb1 (.clk(clk), .en(pix_valid), .din(pix_in), .dout(lb1));
  window_gen_3x3_line_buf #(.W(bit_depth), .DEPTH(IMG_W)) u_lb2 (.clk(clk), .en(pix_valid), .din(lb1), .dout(lb2));
  // sof restarts the frame at this very pixel, so position is forced before use
  always_comb begin
    cur_c = pix_sof ? '0 : col;
    cur_r = pix_sof ? '0 : row;
    last_c = cur_c == COL_W'(IMG_W - 1);
    last_r = cur_r == ROW_W'(IMG_H - 1);
`ifdef WIN_STRIDE2_EN
    win_ok = cur_r >= ROW_W'(2) && cur_c >= COL_W'(2) && !cur_r[0] && !cur_c[0];
`else
    win_ok = cur_r >= ROW_W'(2) && cur_c >= COL_W'(2);
`endif
  end
  always_ff @(posedge clk)
    if (RESET) begin
      row <= '0;
      col <= '0;
      for (int k = 0; k < WIN_N; k++) w[k] <= '0;
      win_valid <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid <= pix_valid && win_ok;
      frame_done <= pix_valid && last_c && last_r;
      if (pix_valid) begin
        for (int i = 0; i < WIN_K; i++) begin
          w[WIN_K*i] <= w[WIN_K*i+1];
          w[WIN_K*i+1] <= w[WIN_K*i+2];
        end
        w[2] <= lb2;
        w[5] <= lb1;
        w[8] <= pix_in;
        win_row <= cur_r;
        win_col <= cur_c;
        col <= last_c ? '0 : cur_c + COL_W'(1);
        row <= last_c ? (last_r ? '0 : cur_r + ROW_W'(1)) : cur_r;
      end
    end
  for (genvar k = 0; k < WIN_N; k++) begin : g_out
    assign win_out[bit_depth*(WIN_N-k)-1 -: bit_depth] = w[k];
  end
endmodule
